pipelined_addsub: RTL and testbench

- Parametrised, segmented, pipelined integer add/subtract unit; multi-bit successor to the single-bit registered adder.
- Splits a WIDTH-bit operation into WIDTH/SEG carry-linked segments, one segment per pipeline stage.
- Accepts one operation per cycle and reports carry, signed overflow and zero flags for the MIPS add/addu/sub/subu datapath.
- Sits between the operand latches and the ALU result mux.

---
 rtl/addsub_pkg.sv | 18 +
 rtl/pipelined_addsub_if.sv | 29 ++
 rtl/addsub_segment.sv | 22 ++
 rtl/pipelined_addsub.sv | 145 ++++++++++++++
 tb/tb_pipelined_addsub.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// Shared constants for the segmented add/subtract pipeline.
// Opcode encoding, default geometry and stage-count derivation.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEG   = 8;

    // One pipeline stage per segment, so the stage count is also the latency.
    function automatic int nseg(input int width, input int seg);
        return width / seg;
    endfunction

    localparam int DEF_NSEG = nseg(DEF_WIDTH, DEF_SEG);

endpackage

// File: rtl/pipelined_addsub_if.sv
// Operand/result bundle for pipelined_addsub; master issues ops, slave is the unit.
// Stall is a whole-pipeline freeze, not a per-beat ready.
interface pipelined_addsub_if
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             En;
    logic             Stall;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Sub;
    logic [WIDTH-1:0] Sum;
    logic             Carry;
    logic             Overflow;
    logic             Zero;
    logic             Valid;

    modport master (
        output En, Stall, A, B, Sub,
        input  Sum, Carry, Overflow, Zero, Valid
    );

    modport slave (
        input  En, Stall, A, B, Sub,
        output Sum, Carry, Overflow, Zero, Valid
    );

endinterface

// File: rtl/addsub_segment.sv
// Combinational SEG-bit adder slice with carry-in; zero latency, no flow control.
// Also reports the carry into its MSB so the top slice can derive signed overflow.
module addsub_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           cmsb
);

    logic [SEG:0] full;

    assign full = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};
    assign sum  = full[SEG-1:0];
    assign cout = full[SEG];
    // The MSB sum bit is a^b^carry_in, so the carry into it falls out for free.
    assign cmsb = a[SEG-1] ^ b[SEG-1] ^ sum[SEG-1];

endmodule

// File: rtl/pipelined_addsub.sv
// Segmented add/sub pipeline: WIDTH/SEG stages, one op/cycle, latency NSEG cycles.
// Stall freezes every stage; ADDSUB_SAT_EN clamps Sum on signed overflow.
module pipelined_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEG   = DEF_SEG
) (
    input  logic               Clk,
    input  logic               Reset,
    pipelined_addsub_if.slave  bus
);

    localparam int NSEG = nseg(WIDTH, SEG);
    localparam int NQ   = (NSEG > 1) ? NSEG - 1 : 1;
    localparam int L    = NSEG - 1;

    // Inter-stage registers: q[k] is the output of stage k, k < NSEG-1.
    logic [NQ-1:0]            vld_q;
    logic [NQ-1:0]            cy_q;
    logic [NQ-1:0][WIDTH-1:0] a_q;
    logic [NQ-1:0][WIDTH-1:0] b_q;
    logic [NQ-1:0][WIDTH-1:0] r_q;

    // Inputs seen by each stage, and the per-stage combinational results.
    logic [NSEG-1:0]            vi;
    logic [NSEG-1:0]            ci;
    logic [NSEG-1:0][WIDTH-1:0] ai;
    logic [NSEG-1:0][WIDTH-1:0] bi;
    logic [NSEG-1:0][WIDTH-1:0] ri;
    logic [NSEG-1:0][WIDTH-1:0] rn;
    logic [NSEG-1:0][SEG-1:0]   seg_sum;
    logic [NSEG-1:0]            seg_co;
    logic [NSEG-1:0]            seg_cm;

    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             ovf_q;
    logic             zero_q;
    logic             valid_q;

    logic             ovf;
    logic [WIDTH-1:0] sum_fin;

    always_comb begin
        vi = '0;
        ci = '0;
        ai = '0;
        bi = '0;
        ri = '0;
        for (int k = 0; k < NSEG; k++) begin
            if (k == 0) begin
                // Subtract is A + ~B + 1: the +1 rides in as segment 0's carry.
                vi[k] = bus.En;
                ci[k] = (bus.Sub == OP_SUB);
                ai[k] = bus.A;
                bi[k] = (bus.Sub == OP_SUB) ? ~bus.B : bus.B;
                ri[k] = '0;
            end else begin
                vi[k] = vld_q[(k > 0) ? k - 1 : 0];
                ci[k] = cy_q[(k > 0) ? k - 1 : 0];
                ai[k] = a_q[(k > 0) ? k - 1 : 0];
                bi[k] = b_q[(k > 0) ? k - 1 : 0];
                ri[k] = r_q[(k > 0) ? k - 1 : 0];
            end
        end
    end

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        addsub_segment #(
            .SEG (SEG)
        ) u_seg (
            .a    (ai[k][k*SEG +: SEG]),
            .b    (bi[k][k*SEG +: SEG]),
            .cin  (ci[k]),
            .sum  (seg_sum[k]),
            .cout (seg_co[k]),
            .cmsb (seg_cm[k])
        );
    end

    always_comb begin
        rn = ri;
        for (int k = 0; k < NSEG; k++) begin
            rn[k][k*SEG +: SEG] = seg_sum[k];
        end
    end

    // Bubbles advance only their valid bit; data registers keep stale contents.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            vld_q <= '0;
            cy_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            r_q   <= '0;
        end else if (!bus.Stall) begin
            for (int k = 0; k < NSEG - 1; k++) begin
                vld_q[k] <= vi[k];
                if (vi[k]) begin
                    cy_q[k] <= seg_co[k];
                    a_q[k]  <= ai[k];
                    b_q[k]  <= bi[k];
                    r_q[k]  <= rn[k];
                end
            end
        end
    end

    assign ovf = seg_cm[L] ^ seg_co[L];

`ifdef ADDSUB_SAT_EN
    // Clamp direction follows A's sign: only same-sign operands can overflow.
    assign sum_fin = !ovf           ? rn[L] :
                     ai[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} :
                                      {1'b0, {(WIDTH-1){1'b1}}};
`else
    assign sum_fin = rn[L];
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (!bus.Stall) begin
            valid_q <= vi[L];
            if (vi[L]) begin
                sum_q   <= sum_fin;
                carry_q <= seg_co[L];
                ovf_q   <= ovf;
                zero_q  <= (sum_fin == '0);
            end
        end
    end

    assign bus.Sum      = sum_q;
    assign bus.Carry    = carry_q;
    assign bus.Overflow = ovf_q;
    assign bus.Zero     = zero_q;
    assign bus.Valid    = valid_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: 32/8 main instance plus an 8/8 single-stage instance.
// Expectations follow the saturating variant when ADDSUB_SAT_EN is defined.
module tb_pipelined_addsub;
    import addsub_pkg::*;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;

    always #5 Clk = ~Clk;

    pipelined_addsub_if #(.WIDTH(32)) bus32();
    pipelined_addsub_if #(.WIDTH(8))  bus8();

    pipelined_addsub #(.WIDTH(32), .SEG(8)) u_dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus32)
    );

    pipelined_addsub #(.WIDTH(8), .SEG(8)) u_dut8 (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus8)
    );

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] sum;
        logic [31:0] sum_sat;
        logic        c;
        logic        o;
        logic        z;
        logic        z_sat;
    } vec_t;

    typedef struct {
        logic        en;
        logic        stall;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
    } drv_t;

    vec_t vecs [9];
    drv_t seq  [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic logic [31:0] exp_sum(input vec_t v);
`ifdef ADDSUB_SAT_EN
        return v.sum_sat;
`else
        return v.sum;
`endif
    endfunction

    function automatic logic exp_zero(input vec_t v);
`ifdef ADDSUB_SAT_EN
        return v.z_sat;
`else
        return v.z;
`endif
    endfunction

    task automatic drive32(input logic en, input logic [31:0] a, input logic [31:0] b, input logic sub);
        bus32.En  = en;
        bus32.A   = a;
        bus32.B   = b;
        bus32.Sub = sub;
    endtask

    task automatic chk_vec(input string tag, input vec_t v);
        chk({tag, "_sum"},  bus32.Sum,             exp_sum(v));
        chk({tag, "_cy"},   {31'd0, bus32.Carry},    {31'd0, v.c});
        chk({tag, "_ovf"},  {31'd0, bus32.Overflow}, {31'd0, v.o});
        chk({tag, "_zero"}, {31'd0, bus32.Zero},     {31'd0, exp_zero(v)});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int nv;
        logic [31:0] snap_sum;
        logic        snap_v;

        //                a             b             sub     sum           sum_sat       c     o     z     z_sat
        vecs[0] = '{32'h0000_0001, 32'hFFFF_FFFF, OP_ADD, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[1] = '{32'h7FFF_FFFF, 32'h0000_0001, OP_ADD, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0005, 32'h0000_0007, OP_SUB, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{32'h8000_0000, 32'h0000_0001, OP_SUB, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{32'h1234_5678, 32'h0F0F_0F0F, OP_ADD, 32'h2143_6587, 32'h2143_6587, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{32'h0000_0003, 32'h0000_0003, OP_SUB, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{32'h0000_0000, 32'h0000_0001, OP_SUB, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{32'h8000_0000, 32'h8000_0000, OP_ADD, 32'h0000_0000, 32'h8000_0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{32'h0100_0000, 32'h0000_0001, OP_SUB, 32'h00FF_FFFF, 32'h00FF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0};

        // Stall spans cycles 4..6 while op0's Valid is showing; cycle 3 is the bubble.
        seq[0]  = '{1'b1, 1'b0, 32'h00FF_FFFF, 32'h0000_0001, OP_ADD};
        seq[1]  = '{1'b1, 1'b0, 32'h0000_0003, 32'h0000_0003, OP_SUB};
        seq[2]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0000_0020, OP_ADD};
        seq[3]  = '{1'b0, 1'b0, 32'hAAAA_AAAA, 32'h5555_5555, OP_ADD};
        seq[4]  = '{1'b1, 1'b1, 32'hDEAD_0000, 32'h0000_BEEF, OP_ADD};
        seq[5]  = '{1'b1, 1'b1, 32'hDEAD_0001, 32'h0000_BEEF, OP_SUB};
        seq[6]  = '{1'b1, 1'b1, 32'hDEAD_0002, 32'h0000_BEEF, OP_ADD};
        seq[7]  = '{1'b1, 1'b0, 32'hFFFF_0000, 32'h0001_0000, OP_ADD};
        for (int i = 8; i < 14; i++) seq[i] = '{1'b0, 1'b0, 32'h0, 32'h0, OP_ADD};

        drive32(1'b0, 32'h0, 32'h0, OP_ADD);
        bus32.Stall = 1'b0;
        bus8.En = 1'b0; bus8.Stall = 1'b0; bus8.A = 8'h0; bus8.B = 8'h0; bus8.Sub = OP_ADD;

        // Reset state
        #12;
        chk("rst_sum",   bus32.Sum, 32'h0);
        chk("rst_vld",   {31'd0, bus32.Valid}, 32'd0);
        chk("rst_cy",    {31'd0, bus32.Carry}, 32'd0);
        chk("rst_zero",  {31'd0, bus32.Zero},  32'd0);
        chk("rst_ovf",   {31'd0, bus32.Overflow}, 32'd0);
        chk("rst_vld8",  {31'd0, bus8.Valid}, 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        step();

        // Isolated ops: Valid must rise on exactly the 4th edge, then drop.
        for (int i = 0; i < 9; i++) begin
            drive32(1'b1, vecs[i].a, vecs[i].b, vecs[i].sub);
            for (int e = 1; e <= 4; e++) begin
                step();
                if (e == 1) bus32.En = 1'b0;
                chk($sformatf("lat%0d_e%0d_vld", i, e), {31'd0, bus32.Valid}, {31'd0, (e == 4)});
            end
            chk_vec($sformatf("vec%0d", i), vecs[i]);
            step();
            chk($sformatf("vec%0d_pulse", i), {31'd0, bus32.Valid}, 32'd0);
        end

        // Same table back-to-back, one op per cycle.
        idx = 0;
        for (int c = 0; c < 20; c++) begin
            if (c < 9) drive32(1'b1, vecs[c].a, vecs[c].b, vecs[c].sub);
            else       drive32(1'b0, 32'h0, 32'h0, OP_ADD);
            step();
            if (bus32.Valid) begin
                if (idx < 9) chk_vec($sformatf("b2b%0d", idx), vecs[idx]);
                idx++;
            end
        end
        chk("b2b_count", idx, 32'd9);

        // Stream with bubble and 3-cycle stall.
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            drive32(seq[c].en, seq[c].a, seq[c].b, seq[c].sub);
            bus32.Stall = seq[c].stall;
            snap_sum = bus32.Sum;
            snap_v   = bus32.Valid;
            step();
            if (seq[c].stall) begin
                chk($sformatf("stall%0d_sum", c), bus32.Sum, snap_sum);
                chk($sformatf("stall%0d_vld", c), {31'd0, bus32.Valid}, {31'd0, snap_v});
            end else if (bus32.Valid) begin
                case (idx)
                    0: begin
                        chk("strm0_sum", bus32.Sum, 32'h0100_0000);
                        chk("strm0_cy", {31'd0, bus32.Carry}, 32'd0);
                    end
                    1: begin
                        chk("strm1_sum", bus32.Sum, 32'h0000_0000);
                        chk("strm1_zero", {31'd0, bus32.Zero}, 32'd1);
                    end
                    2: begin
                        chk("strm2_sum", bus32.Sum, 32'h0000_0030);
                        chk("strm2_zero", {31'd0, bus32.Zero}, 32'd0);
                    end
                    3: begin
                        chk("strm3_sum", bus32.Sum, 32'h0000_0000);
                        chk("strm3_cy", {31'd0, bus32.Carry}, 32'd1);
                        chk("strm3_ovf", {31'd0, bus32.Overflow}, 32'd0);
                    end
                    default: chk("strm_extra_valid", 32'd1, 32'd0);
                endcase
                idx++;
            end
        end
        chk("strm_count", idx, 32'd4);
        bus32.Stall = 1'b0;

        // Async reset mid-flight: op0 showing, op1/op2 in the pipe.
        drive32(1'b1, 32'h1111_1111, 32'h2222_2222, OP_ADD); step();
        drive32(1'b1, 32'h0000_0005, 32'h0000_0005, OP_ADD); step();
        drive32(1'b1, 32'h0000_0006, 32'h0000_0006, OP_ADD); step();
        drive32(1'b0, 32'h0, 32'h0, OP_ADD);                 step();
        chk("prerst_vld", {31'd0, bus32.Valid}, 32'd1);
        chk("prerst_sum", bus32.Sum, 32'h3333_3333);
        #3;
        Reset = 1'b1;
        #1;
        chk("arst_sum",  bus32.Sum, 32'h0);
        chk("arst_vld",  {31'd0, bus32.Valid}, 32'd0);
        chk("arst_cy",   {31'd0, bus32.Carry}, 32'd0);
        chk("arst_zero", {31'd0, bus32.Zero},  32'd0);
        @(posedge Clk);
        #2;
        Reset = 1'b0;
        nv = 0;
        for (int c = 0; c < 8; c++) begin
            step();
            if (bus32.Valid) nv++;
        end
        chk("postrst_no_valid", nv, 32'd0);
        chk("postrst_sum", bus32.Sum, 32'h0);

        drive32(1'b1, 32'h0000_0002, 32'h0000_0003, OP_ADD);
        step();
        bus32.En = 1'b0;
        step(); step(); step();
        chk("postrst_new_vld", {31'd0, bus32.Valid}, 32'd1);
        chk("postrst_new_sum", bus32.Sum, 32'h0000_0005);

        // Single-stage 8-bit instance.
        bus8.En = 1'b1; bus8.A = 8'h80; bus8.B = 8'h80; bus8.Sub = OP_ADD;
        step();
        bus8.En = 1'b0;
        chk("w8_vld", {31'd0, bus8.Valid}, 32'd1);
`ifdef ADDSUB_SAT_EN
        chk("w8_sum",  {24'd0, bus8.Sum}, 32'h80);
        chk("w8_zero", {31'd0, bus8.Zero}, 32'd0);
`else
        chk("w8_sum",  {24'd0, bus8.Sum}, 32'h00);
        chk("w8_zero", {31'd0, bus8.Zero}, 32'd1);
`endif
        chk("w8_cy",   {31'd0, bus8.Carry}, 32'd1);
        chk("w8_ovf",  {31'd0, bus8.Overflow}, 32'd1);
        step();
        chk("w8_pulse", {31'd0, bus8.Valid}, 32'd0);

        bus8.En = 1'b1; bus8.A = 8'h10; bus8.B = 8'h20; bus8.Sub = OP_SUB;
        step();
        bus8.En = 1'b0;
        chk("w8s_vld", {31'd0, bus8.Valid}, 32'd1);
        chk("w8s_sum", {24'd0, bus8.Sum}, 32'hF0);
        chk("w8s_cy",  {31'd0, bus8.Carry}, 32'd0);
        chk("w8s_ovf", {31'd0, bus8.Overflow}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
